stream_median_filter: RTL



---
 rtl/stream_median_filter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/stream_median_filter.sv
// 3x3 per-channel median filter over a raster pixel stream.
// Two line buffers feed a sliding window; bypass passes the centre tap.
module stream_median_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_data,
  output logic                           m_sof,
  output logic                           m_eol,
  input  logic                           border_mode,
  input  logic                           bypass,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int PW   = CHANNELS * DATA_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW   = $clog2(NPIX);
  localparam int XW   = $clog2(IMG_WIDTH);
  localparam int YW   = $clog2(IMG_HEIGHT);
  localparam int GW   = $clog2(IMG_WIDTH + 2);

  localparam logic [CW-1:0] FILL_END = CW'(IMG_WIDTH + 1);
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_HEIGHT - 1);
  localparam logic [GW-1:0] G_LAST   = GW'(IMG_WIDTH);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [XW-1:0] in_col;
  logic [GW-1:0] gen_cnt;
  logic [YW-1:0] out_r;
  logic [XW-1:0] out_c;
  logic [YW-1:0] ra;
  logic [XW-1:0] ca;
  logic          mode_q;
  logic          byp_q;
  logic          va;
  logic          vb;
  logic          sof_b;
  logic          eol_b;

  logic [PW-1:0] lb0 [IMG_WIDTH];
  logic [PW-1:0] lb1 [IMG_WIDTH];
  logic [PW-1:0] wa  [3][3];
  logic [PW-1:0] wb  [3][3];
  logic [PW-1:0] mw  [3][3];

  logic          en;
  logic          in_xfer;
  logic          gen;
  logic          step;
  logic          produce;
  logic          out_xfer;
  logic [PW-1:0] new_bot;
  logic [PW-1:0] top_rd;
  logic [PW-1:0] mid_rd;
  logic [PW-1:0] res;
  logic [8:0][DW-1:0] tap;

  assign en       = !(m_valid && !m_ready);
  assign s_ready  = !rst && en && (state != FLUSH);
  assign in_xfer  = s_valid && s_ready;
  assign gen      = (state == FLUSH) && en && (gen_cnt <= G_LAST);
  assign step     = in_xfer || gen;
  assign produce  = gen || (in_xfer && (in_cnt >= FILL_END));
  assign out_xfer = m_valid && m_ready;
  assign new_bot  = gen ? '0 : s_data;
  assign top_rd   = lb1[in_col];
  assign mid_rd   = lb0[in_col];

  function automatic logic [2*DW-1:0] cas(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    return (a > b) ? {b, a} : {a, b};
  endfunction

  function automatic logic [DW-1:0] med9(input logic [8:0][DW-1:0] v);
    logic [8:0][DW-1:0] p;
    p = v;
    {p[1], p[2]} = cas(p[1], p[2]);
    {p[4], p[5]} = cas(p[4], p[5]);
    {p[7], p[8]} = cas(p[7], p[8]);
    {p[0], p[1]} = cas(p[0], p[1]);
    {p[3], p[4]} = cas(p[3], p[4]);
    {p[6], p[7]} = cas(p[6], p[7]);
    {p[1], p[2]} = cas(p[1], p[2]);
    {p[4], p[5]} = cas(p[4], p[5]);
    {p[7], p[8]} = cas(p[7], p[8]);
    {p[0], p[3]} = cas(p[0], p[3]);
    {p[5], p[8]} = cas(p[5], p[8]);
    {p[4], p[7]} = cas(p[4], p[7]);
    {p[3], p[6]} = cas(p[3], p[6]);
    {p[1], p[4]} = cas(p[1], p[4]);
    {p[2], p[5]} = cas(p[2], p[5]);
    {p[4], p[7]} = cas(p[4], p[7]);
    {p[4], p[2]} = cas(p[4], p[2]);
    {p[6], p[4]} = cas(p[6], p[4]);
    {p[4], p[2]} = cas(p[4], p[2]);
    return p[4];
  endfunction

  // Flush steps push a virtual zero row; the border mask hides it.
  always_ff @(posedge clk) begin
    if (step) begin
      lb1[in_col] <= mid_rd;
      lb0[in_col] <= new_bot;
    end
  end

  always_ff @(posedge clk) begin
    if (step) begin
      for (int r = 0; r < 3; r++) begin
        wa[r][0] <= wa[r][1];
        wa[r][1] <= wa[r][2];
      end
      wa[0][2] <= top_rd;
      wa[1][2] <= mid_rd;
      wa[2][2] <= new_bot;
    end
    if (en) wb <= mw;
  end

  // Columns first, then rows, so clamped corners pick the centre.
  always_comb begin
    mw = wa;
    if (ca == '0)
      for (int r = 0; r < 3; r++) mw[r][0] = mode_q ? wa[r][1] : '0;
    if (ca == X_LAST)
      for (int r = 0; r < 3; r++) mw[r][2] = mode_q ? wa[r][1] : '0;
    if (ra == '0)
      for (int c = 0; c < 3; c++) mw[0][c] = mode_q ? mw[1][c] : '0;
    if (ra == Y_LAST)
      for (int c = 0; c < 3; c++) mw[2][c] = mode_q ? mw[1][c] : '0;
  end

  always_comb begin
    res = '0;
    tap = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          tap[r*3+c] = wb[r][c][k*DW +: DW];
      res[k*DW +: DW] = byp_q ? wb[1][1][k*DW +: DW] : med9(tap);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      in_col     <= '0;
      gen_cnt    <= '0;
      out_r      <= '0;
      out_c      <= '0;
      ra         <= '0;
      ca         <= '0;
      mode_q     <= 1'b0;
      byp_q      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      va         <= 1'b0;
      vb         <= 1'b0;
      sof_b      <= 1'b0;
      eol_b      <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (en) begin
        va      <= produce;
        vb      <= va;
        sof_b   <= (ra == '0) && (ca == '0);
        eol_b   <= (ca == X_LAST);
        m_valid <= vb;
        m_data  <= res;
        m_sof   <= sof_b;
        m_eol   <= eol_b;
      end
      if (produce) begin
        ra <= out_r;
        ca <= out_c;
        if (out_c == X_LAST) begin
          out_c <= '0;
          out_r <= out_r + YW'(1);
        end else begin
          out_c <= out_c + XW'(1);
        end
      end
      if (step) in_col <= (in_col == X_LAST) ? '0 : in_col + XW'(1);
      if (in_xfer) in_cnt <= in_cnt + CW'(1);
      if (gen) gen_cnt <= gen_cnt + GW'(1);
      if (out_xfer) out_cnt <= out_cnt + CW'(1);
      unique case (state)
        IDLE: if (in_xfer) begin
          state  <= FILL;
          busy   <= 1'b1;
          mode_q <= border_mode;
          byp_q  <= bypass;
        end
        FILL: if (in_xfer && in_cnt == FILL_END) state <= RUN;
        RUN: if (in_xfer && in_cnt == LAST_PIX) state <= FLUSH;
        FLUSH: if (out_xfer && out_cnt == LAST_PIX) begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
          in_cnt     <= '0;
          out_cnt    <= '0;
          in_col     <= '0;
          gen_cnt    <= '0;
          out_r      <= '0;
          out_c      <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
